// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: one DIGIT-wide slice reused over N=WIDTH/DIGIT cycles, LSD first.
// Latency N edges from start to done; start is ignored while busy and accepted again in the DONE cycle.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt, dig_ext;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   dsum;
    logic             cin_msb;
    logic             last;
    logic             accept;

    always_comb begin
        dsum    = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        // Carry into the digit's top bit recovered from its sum bit; also covers DIGIT=1.
        cin_msb = dsum[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];
        dig_ext = '0;
        dig_ext[DIGIT-1:0] = dsum[DIGIT-1:0];
        res_nxt = (res_sr >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
        last    = (cnt == CW'(N - 1));
        accept  = start && (state == IDLE || state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            res_sr <= res_nxt;
            carry  <= dsum[DIGIT];
            cnt    <= cnt + CW'(1);
            if (last) begin
                sum  <= res_nxt;
                cout <= dsum[DIGIT];
                ovf  <= cin_msb ^ dsum[DIGIT];
            end
        end
    end
endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for two digit_serial_adder instances (16/4 and 8/1) with a result scoreboard.
module tb_digit_serial_adder;
    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        v;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        start16, sub16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    logic        start8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;

    res_t        q16[$];
    res_t        q8[$];
    res_t        e;
    logic [15:0] prev_sum16;
    int          n_cmp;
    int          n_err;
    int          edges;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop16(output res_t r);
        check("q16_nonempty", 32'(q16.size() > 0), 32'd1);
        r = (q16.size() > 0) ? q16.pop_front() : '0;
    endtask

    // One 16-bit operation; junk keeps start high with other operands during RUN.
    task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic ts, input res_t exp, input bit junk);
        int busyc;
        res_t r;
        @(negedge clk);
        a16 = ta; b16 = tb_; sub16 = ts; start16 = 1'b1;
        q16.push_back(exp);
        @(negedge clk);
        edges = 0;
        busyc = 0;
        if (junk) begin
            a16 = 16'hAAAA; b16 = 16'h5555; sub16 = 1'b0;
        end else begin
            start16 = 1'b0;
        end
        while (!done16 && edges < 40) begin
            if (busy16) busyc++;
            check({tag, "_hold"}, 32'(sum16), 32'(prev_sum16));
            if (junk && edges == 1) start16 = 1'b0;
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'd4);
        check({tag, "_busycycles"}, 32'(busyc), 32'd4);
        check({tag, "_busy_at_done"}, 32'(busy16), 32'd0);
        pop16(r);
        check({tag, "_sum"}, 32'(sum16), 32'(r.s));
        check({tag, "_cout"}, 32'(cout16), 32'(r.c));
        check({tag, "_ovf"}, 32'(ovf16), 32'(r.v));
        prev_sum16 = r.s;
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done16), 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; prev_sum16 = '0;
        rst_n = 1'b0;
        start16 = 0; sub16 = 0; a16 = '0; b16 = '0;
        start8 = 0;  sub8 = 0;  a8 = '0;  b8 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy16", 32'(busy16), 32'd0);
        check("rst_done16", 32'(done16), 32'd0);
        check("rst_sum16", 32'(sum16), 32'd0);
        check("rst_flags16", 32'({cout16, ovf16}), 32'd0);
        check("rst_state8", 32'({busy8, done8, sum8, cout8, ovf8}), 32'd0);

        run16("add_basic", 16'h1234, 16'h4321, 1'b0, {16'h5555, 1'b0, 1'b0}, 1'b0);
        run16("add_wrap",  16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b0}, 1'b0);
        run16("add_povf",  16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1}, 1'b0);
        run16("add_novf",  16'h8000, 16'h8000, 1'b0, {16'h0000, 1'b1, 1'b1}, 1'b0);
        run16("sub_neg",   16'h0005, 16'h0007, 1'b1, {16'hFFFE, 1'b0, 1'b0}, 1'b0);
        run16("sub_ovf",   16'h8000, 16'h0001, 1'b1, {16'h7FFF, 1'b1, 1'b1}, 1'b0);
        run16("sub_eq",    16'h1234, 16'h1234, 1'b1, {16'h0000, 1'b1, 1'b0}, 1'b0);
        run16("start_ign", 16'h0001, 16'h0001, 1'b0, {16'h0002, 1'b0, 1'b0}, 1'b1);

        // Abort between the 2nd and 3rd RUN edges.
        @(negedge clk);
        a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy16), 32'd0);
        check("arst_sum", 32'(sum16), 32'd0);
        check("arst_flags", 32'({done16, cout16, ovf16}), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            check("arst_nodone", 32'(done16), 32'd0);
        end
        prev_sum16 = '0;
        run16("post_rst", 16'h0010, 16'h0020, 1'b0, {16'h0030, 1'b0, 1'b0}, 1'b0);

        // DIGIT=1 instance, start held high across a back-to-back accept.
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
        q8.push_back({16'h0010, 1'b0, 1'b0});
        @(negedge clk);
        edges = 0;
        while (!done8 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check("d1_latency1", 32'(edges), 32'd8);
        check("q8_nonempty1", 32'(q8.size() > 0), 32'd1);
        e = (q8.size() > 0) ? q8.pop_front() : '0;
        check("d1_sum1", 32'(sum8), 32'(e.s));
        check("d1_flags1", 32'({cout8, ovf8}), 32'({e.c, e.v}));
        a8 = 8'h80; b8 = 8'h01; sub8 = 1'b1;
        q8.push_back({16'h007F, 1'b1, 1'b1});
        edges = 0;
        @(negedge clk);
        edges++;
        check("d1_b2b_busy", 32'(busy8), 32'd1);
        check("d1_b2b_done", 32'(done8), 32'd0);
        check("d1_hold", 32'(sum8), 32'h10);
        start8 = 1'b0;
        while (!done8 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check("d1_latency2", 32'(edges), 32'd9);
        check("q8_nonempty2", 32'(q8.size() > 0), 32'd1);
        e = (q8.size() > 0) ? q8.pop_front() : '0;
        check("d1_sum2", 32'(sum8), 32'(e.s));
        check("d1_flags2", 32'({cout8, ovf8}), 32'({e.c, e.v}));
        @(negedge clk);
        check("d1_idle", 32'({busy8, done8}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
